dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the wait-state cycles between request accept and response (legal range 0..15).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, meaning the byte address of word 0.
REQ-004 SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, 1, meaning the initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1, meaning the responder accepts a request this cycle.
REQ-008 SHALL have port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, 32, the byte address.
REQ-010 SHALL have port req_wdata, input, 32, the store data.
REQ-011 SHALL have port req_wstrb, input, 4, the per-byte write enables (bit i covers wdata[8i+7:8i]).
REQ-012 SHALL have port rsp_valid, output, 1, meaning a response is presented.
REQ-013 SHALL have port rsp_ready, input, 1, meaning the initiator consumes the response.
REQ-014 SHALL have port rsp_rdata, output, 32, the load data.
REQ-015 SHALL have port rsp_err, output, 1, meaning the request was rejected.

Function
REQ-016 SHALL implement the FSM states IDLE, WAIT and RESP, with exactly one request outstanding.
REQ-017 SHALL in IDLE drive req_ready=1 and rsp_valid=0; in WAIT and RESP it SHALL drive req_ready=0.
REQ-018 SHALL on accept (req_valid & req_ready at edge N) capture we/addr/wdata/wstrb; request inputs outside accept SHALL be ignored.
REQ-019 SHALL go to WAIT with counter=LATENCY-1 when LATENCY>0, decrementing each cycle and moving to RESP at the edge where counter==0; when LATENCY==0 it SHALL go directly to RESP.
REQ-020 SHALL first assert rsp_valid in the cycle after edge N+LATENCY.
REQ-021 SHALL perform the commit on the edge entering RESP: stores write only the strobed bytes; loads register the word into rsp_rdata.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1.
REQ-023 SHALL on the rsp_ready handshake return to IDLE, with req_ready=1 in the next cycle; throughput is 1 request per LATENCY+2 cycles minimum.
REQ-024 SHALL set rsp_err=1 when the captured address is misaligned (addr[1:0]!=0), below BASE_ADDR, or at/above BASE_ADDR+4*DEPTH.
REQ-025 SHALL on an error perform no memory write and drive rsp_rdata=0.
REQ-026 SHALL drive rsp_rdata=0 on any store response.
REQ-027 SHALL treat a store with wstrb=4'b0000 as a legal no-op with rsp_err=0.
REQ-028 SHALL compute word index = (addr-BASE_ADDR)>>2 with 32-bit unsigned arithmetic; wrap-around below BASE_ADDR SHALL be caught by the range check.

Reset
REQ-029 SHALL on reset go to IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0.
REQ-030 SHALL abort any in-flight request when reset asserts mid-operation: no write and no response.
REQ-031 SHALL NOT reset memory contents.

Structure
REQ-032 SHALL place the state enum (IDLE/WAIT/RESP) and the LATENCY width constant in package dmem_resp_pkg.
REQ-033 SHALL implement the wait-state countdown in sub-module wait_counter (load, decrement, done).
REQ-034 SHALL implement storage as a DEPTH x 32 array with per-byte write.

Verification
REQ-035 SHALL cover store then load with LATENCY=2: store 0x60 <- 0x0000_0019, wstrb=1111, accepted at edge N -> rsp_valid high after edge N+2, rsp_err=0; load 0x60 -> rsp_rdata=0x0000_0019.
REQ-036 SHALL cover a byte store: word 0x64=0xAABBCCDD, store 0x11223344 with wstrb=0010 -> load returns 0xAABB33DD.
REQ-037 SHALL cover errors: load 0x62 -> rsp_err=1, rsp_rdata=0; store 0x100 (DEPTH=64) -> rsp_err=1, memory unchanged.
REQ-038 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_rdata held, req_ready=0, and a second req_valid is not accepted until 1 cycle after the handshake.
REQ-039 SHALL cover LATENCY=0: request accepted at edge N -> rsp_valid high after edge N.
REQ-040 SHALL cover reset in WAIT during a store to 0x60 -> no write (0x60 retains its old value), rsp_valid=0, req_ready=1.

Source files
------------

// File: rtl/dmem_resp_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_resp_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for the full 0..15 wait-state range.
  localparam int LAT_W = 4;
endpackage

// File: rtl/wait_counter.sv
// Wait-state countdown: load a start value, decrement once per cycle, flag zero.
module wait_counter
  import dmem_resp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);
  logic [LAT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding word memory responder with programmable wait states,
// per-byte stores and address range/alignment error reporting.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0]      SPAN     = 33'(DEPTH) << 2;
  localparam logic [LAT_W-1:0] LOAD_VAL = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  state_t state, state_next;
  logic   accept, commit, cnt_load, cnt_dec, cnt_done;

  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  logic        cur_we;
  logic [31:0] cur_addr, cur_wdata;
  logic [3:0]  cur_wstrb;
  logic [31:0] off;
  logic        addr_err;
  logic [IDX_W-1:0] idx;

  logic [31:0] mem [DEPTH];

  wait_counter u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (LOAD_VAL),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_load   = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_done) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= req_we;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_wstrb <= req_wstrb;
    end
  end

  // With zero wait states the commit happens on the accept edge itself,
  // so it must see the live request rather than the captured copy.
  always_comb begin
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_wstrb = req_wstrb;
    end else begin
      cur_we    = cap_we;
      cur_addr  = cap_addr;
      cur_wdata = cap_wdata;
      cur_wstrb = cap_wstrb;
    end
  end

  // Wrap-around below BASE_ADDR shows up as a huge offset and fails the span test too.
  assign off      = cur_addr - BASE_ADDR;
  assign addr_err = (cur_addr[1:0] != 2'b00) || (cur_addr < BASE_ADDR) ||
                    ({1'b0, off} >= SPAN);
  assign idx      = IDX_W'(off >> 2);

  always_ff @(posedge clk) begin
    if (commit && !reset && cur_we && !addr_err) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_wstrb[b]) begin
          mem[idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= addr_err;
      rsp_rdata <= (addr_err || cur_we) ? 32'h0 : mem[idx];
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: two instances (2 wait states at base 0,
// zero wait states at base 0x1000) checked against an array-based memory model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_wstrb [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int          lat   [2] = '{2, 0};
  int          depth [2] = '{64, 16};
  int unsigned base  [2] = '{32'h0, 32'h1000};

  logic [31:0] m0 [64];
  logic [31:0] m1 [16];

  int checks   = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(64), .LATENCY(2), .BASE_ADDR(32'h0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_wstrb(req_wstrb[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(16), .LATENCY(0), .BASE_ADDR(32'h1000)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_wstrb(req_wstrb[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mread(input int d, input int i);
    return (d == 0) ? m0[i] : m1[i];
  endfunction

  task automatic mwrite(input int d, input int i, input logic [31:0] v);
    if (d == 0) m0[i] = v;
    else        m1[i] = v;
  endtask

  // One full transaction: accept, wait-state check, response check,
  // optional backpressure with a competing request held on the inputs.
  task automatic txn(input int d, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wstrb, input int hold);
    logic        err;
    logic [31:0] off, exp_rd, w;
    int          idx;
    off    = addr - base[d];
    err    = (addr[1:0] != 2'b00) || (longint'(addr) < longint'(base[d])) ||
             (longint'(off) >= longint'(4 * depth[d]));
    idx    = int'(off >> 2);
    exp_rd = 32'h0;
    if (!err) begin
      w = mread(d, idx);
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mwrite(d, idx, w);
      end else begin
        exp_rd = w;
      end
    end

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wstrb[d] = wstrb;
    rsp_ready[d] = 1'b0;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_we[d]    = 1'b1;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    req_wstrb[d] = 4'hF;
    for (int k = 0; k < lat[d]; k++) begin
      chk("rsp_valid_wait", 32'(rsp_valid[d]), 32'd0);
      chk("req_ready_wait", 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
    end
    chk("rsp_valid", 32'(rsp_valid[d]), 32'd1);
    chk("rsp_err", 32'(rsp_err[d]), 32'(err));
    chk("rsp_rdata", rsp_rdata[d], exp_rd);
    for (int h = 0; h < hold; h++) begin
      req_valid[d] = 1'b1;
      req_addr[d]  = base[d] + 32'($urandom_range(0, depth[d] - 1) * 4);
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], exp_rd);
      chk("hold_err", 32'(rsp_err[d]), 32'(err));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b0;
    chk("post_hs_valid", 32'(rsp_valid[d]), 32'd0);
    chk("post_hs_req_ready", 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    int          d;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_addr[i] = '0;
      req_wdata[i] = '0;   req_wstrb[i] = '0; rsp_ready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
      chk("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) txn(0, 1'b1, 32'(i * 4), $urandom, 4'hF, 0);
    for (int i = 0; i < 16; i++) txn(1, 1'b1, 32'h1000 + 32'(i * 4), $urandom, 4'hF, 0);

    // Directed cases
    txn(0, 1'b1, 32'h60, 32'h0000_0019, 4'b1111, 0);
    txn(0, 1'b0, 32'h60, 32'h0, 4'b0000, 0);
    txn(0, 1'b1, 32'h64, 32'hAABB_CCDD, 4'b1111, 0);
    txn(0, 1'b1, 32'h64, 32'h1122_3344, 4'b0010, 0);
    txn(0, 1'b0, 32'h64, 32'h0, 4'b0000, 0);
    chk("byte_store_model", m0[25], 32'hAABB_33DD);
    txn(0, 1'b0, 32'h62, 32'h0, 4'b0000, 0);
    txn(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 4'b1111, 0);
    txn(0, 1'b1, 32'h68, 32'h1234_5678, 4'b0000, 0);
    txn(0, 1'b0, 32'h68, 32'h0, 4'b0000, 5);
    txn(0, 1'b0, 32'hFC, 32'h0, 4'b0000, 0);
    txn(1, 1'b1, 32'h1010, 32'hCAFE_F00D, 4'b1001, 0);
    txn(1, 1'b0, 32'h1010, 32'h0, 4'b0000, 2);
    txn(1, 1'b0, 32'h0FFC, 32'h0, 4'b0000, 0);
    txn(1, 1'b1, 32'h0, 32'h5555_5555, 4'b1111, 0);
    txn(1, 1'b0, 32'h1040, 32'h0, 4'b0000, 0);
    txn(1, 1'b0, 32'h103C, 32'h0, 4'b0000, 0);

    // Reset while a store sits in its wait states: nothing may be written.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h60;
    req_wdata[0] = ~m0[24]; req_wstrb[0] = 4'hF;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("abort_in_wait", 32'(rsp_valid[0]), 32'd0);
    reset = 1'b1;
    #2;
    chk("abort_req_ready", 32'(req_ready[0]), 32'd1);
    chk("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_rsp_rdata", rsp_rdata[0], 32'd0);
    chk("abort_rsp_err", 32'(rsp_err[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_still_idle", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    txn(0, 1'b0, 32'h60, 32'h0, 4'b0000, 0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      d = int'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       a = base[d] + 32'($urandom_range(0, depth[d] * 4 - 1));
        1:       a = $urandom;
        default: a = base[d] + 32'($urandom_range(0, depth[d] - 1) * 4);
      endcase
      txn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom),
          int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 64; i++) txn(0, 1'b0, 32'(i * 4), 32'h0, 4'h0, 0);
    for (int i = 0; i < 16; i++) txn(1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
